// File: rtl/grad_dir_encoder_pkg.sv
// Shared gradient-encoding definitions for the Sobel -> NMS path.
// Direction codes and tangent thresholds are also used by the NMS block.
package grad_dir_encoder_pkg;
    typedef enum logic [1:0] {
        DIR_N  = 2'b00,
        DIR_E  = 2'b01,
        DIR_NW = 2'b10,
        DIR_NE = 2'b11
    } grad_dir_e;

    // tan(22.5deg) and tan(67.5deg) in Q8
    localparam int TAN22_Q8    = 106;
    localparam int TAN67_Q8    = 618;
    localparam int GRAD_MAG_W  = 24;
    localparam int GRAD_DIR_W  = 2;
    localparam int GRAD_DATA_W = GRAD_DIR_W + GRAD_MAG_W;
endpackage

// File: rtl/grad_dir_encoder_if.sv
// Pixel stream into and out of the gradient encoder.
// master drives gradients and side-band; slave is the encoder.
interface grad_dir_encoder_if
    import grad_dir_encoder_pkg::*;
#(
    parameter int G_WIDTH = 11
);
    logic                      start;
    logic                      matrix_clken;
    logic                      data_valid;
    logic signed [G_WIDTH-1:0] gx;
    logic signed [G_WIDTH-1:0] gy;
    logic                      start_sync;
    logic                      matrix_clken_o;
    logic                      data_valid_o;
    logic [GRAD_DATA_W-1:0]    grad_o;
    logic                      frame_done;

    modport master (
        output start, matrix_clken, data_valid, gx, gy,
        input  start_sync, matrix_clken_o, data_valid_o, grad_o, frame_done
    );
    modport slave (
        input  start, matrix_clken, data_valid, gx, gy,
        output start_sync, matrix_clken_o, data_valid_o, grad_o, frame_done
    );
endinterface

// File: rtl/grad_dir_encoder_quant.sv
// Quantises a gradient to one of four directions from Q8 tangent compares.
// Purely combinational; the top registers the result.
module grad_dir_quant
    import grad_dir_encoder_pkg::*;
#(
    parameter int SQ_W = 22
) (
    input  logic [SQ_W-1:0] ay256,
    input  logic [SQ_W-1:0] ax106,
    input  logic [SQ_W-1:0] ax618,
    input  logic            sx,
    input  logic            sy,
    output grad_dir_e       dir
);
    // Equal signs put the edge normal on the p11/p33 diagonal (y grows downward)
    always_comb begin
        dir = DIR_E;
        if (ay256 <= ax106)      dir = DIR_E;
        else if (ay256 >= ax618) dir = DIR_N;
        else if (sx == sy)       dir = DIR_NW;
        else                     dir = DIR_NE;
    end
endmodule

// File: rtl/grad_dir_encoder.sv
// Sobel gx/gy -> {dir, mag_sq} encoder, 3-clk latency, with frame position counters.
// GRAD_BORDER_ZERO_EN: zero the output of frame-border pixels.
module grad_dir_encoder
    import grad_dir_encoder_pkg::*;
#(
    parameter int WIDTH   = 634,
    parameter int DEPTH   = 506,
    parameter int G_WIDTH = 11
) (
    input logic               clk,
    input logic               rst_n,
    grad_dir_encoder_if.slave bus
);
    localparam int SQ_W   = 2 * G_WIDTH;
    localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STAGES = 1;

    logic               acc;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               col_end, row_end, border;
    logic               sx, sy;
    logic [G_WIDTH-1:0] ax, ay;

    logic [STAGES:0]    vld_pipe;
    logic [G_WIDTH-1:0] s1_ax, s1_ay;
    logic               s1_sx, s1_sy, s1_last, s1_border;
    logic [SQ_W-1:0]    s2_sqx, s2_sqy, s2_ay256, s2_ax106, s2_ax618;
    logic               s2_sx, s2_sy, s2_last, s2_border;
    grad_dir_e          dir;
    logic [2:0][2:0]    sb_pipe;
    logic [GRAD_DATA_W-1:0] grad_q;
    logic               fd_q;

    assign acc     = bus.start & bus.matrix_clken & ~bus.data_valid;
    assign col_end = (col == CW'(WIDTH - 1));
    assign row_end = (row == RW'(DEPTH - 1));
    assign sx      = bus.gx[G_WIDTH-1];
    assign sy      = bus.gy[G_WIDTH-1];
    // Unsigned view keeps |-2^(G_WIDTH-1)| representable
    assign ax      = sx ? (~bus.gx + G_WIDTH'(1)) : bus.gx;
    assign ay      = sy ? (~bus.gy + G_WIDTH'(1)) : bus.gy;

`ifdef GRAD_BORDER_ZERO_EN
    assign border = (col == '0) | col_end | (row == '0) | row_end;
`else
    assign border = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!bus.start) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_ax     <= '0;
            s1_ay     <= '0;
            s1_sx     <= 1'b0;
            s1_sy     <= 1'b0;
            s1_last   <= 1'b0;
            s1_border <= 1'b0;
            s2_sqx    <= '0;
            s2_sqy    <= '0;
            s2_ay256  <= '0;
            s2_ax106  <= '0;
            s2_ax618  <= '0;
            s2_sx     <= 1'b0;
            s2_sy     <= 1'b0;
            s2_last   <= 1'b0;
            s2_border <= 1'b0;
            grad_q    <= '0;
            fd_q      <= 1'b0;
            sb_pipe   <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], acc};
            s1_ax     <= ax;
            s1_ay     <= ay;
            s1_sx     <= sx;
            s1_sy     <= sy;
            s1_last   <= col_end & row_end;
            s1_border <= border;
            s2_sqx    <= SQ_W'(s1_ax) * SQ_W'(s1_ax);
            s2_sqy    <= SQ_W'(s1_ay) * SQ_W'(s1_ay);
            s2_ay256  <= SQ_W'(s1_ay) << 8;
            s2_ax106  <= SQ_W'(s1_ax) * SQ_W'(TAN22_Q8);
            s2_ax618  <= SQ_W'(s1_ax) * SQ_W'(TAN67_Q8);
            s2_sx     <= s1_sx;
            s2_sy     <= s1_sy;
            s2_last   <= s1_last;
            s2_border <= s1_border;
            if (vld_pipe[STAGES] && !s2_border)
                grad_q <= {dir, GRAD_MAG_W'(s2_sqx) + GRAD_MAG_W'(s2_sqy)};
            else
                grad_q <= '0;
            fd_q      <= vld_pipe[STAGES] & s2_last;
            sb_pipe   <= {sb_pipe[1:0], {bus.start, bus.matrix_clken, bus.data_valid}};
        end
    end

    grad_dir_quant #(.SQ_W(SQ_W)) u_quant (
        .ay256 (s2_ay256),
        .ax106 (s2_ax106),
        .ax618 (s2_ax618),
        .sx    (s2_sx),
        .sy    (s2_sy),
        .dir   (dir)
    );

    assign bus.grad_o         = grad_q;
    assign bus.frame_done     = fd_q;
    assign bus.start_sync     = sb_pipe[2][2];
    assign bus.matrix_clken_o = sb_pipe[2][1];
    assign bus.data_valid_o   = sb_pipe[2][0];
endmodule
